// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: oversamples sclk_n/cs_n/mosi on clk, shifts in
// fixed-length MSB-first frames and emits header + sample with a one-cycle strobe.
module spi_frame_rx #(
  parameter int FRAME_W = 16,
  parameter int HDR_W   = 4,
  parameter int DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              ena,
  input  logic              sclk_n,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [HDR_W-1:0]  hdr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_W);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1, mosi_p2;
  logic [1:0] warm;
  logic armed;
  logic sclk_rise, cs_rise, cs_fall;

  logic [FRAME_W-1:0] shreg;
  logic [4:0]         cnt;

  function automatic logic [4:0] cnt_sat_inc(input logic [4:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + 5'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: history flop for edge detection
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      {sclk_p0, sclk_p1, sclk_p2} <= 3'b111;
      {cs_p0, cs_p1, cs_p2}       <= 3'b111;
      {mosi_p0, mosi_p1, mosi_p2} <= 3'b000;
      warm                        <= 2'd0;
    end else begin
      {sclk_p0, sclk_p1, sclk_p2} <= {sclk_n, sclk_p0, sclk_p1};
      {cs_p0, cs_p1, cs_p2}       <= {cs_n, cs_p0, cs_p1};
      {mosi_p0, mosi_p1, mosi_p2} <= {mosi, mosi_p0, mosi_p1};
      if (warm != 2'd3)
        warm <= warm + 2'd1;
    end
  end

  // The chain resets to 1, so a cs_n already low at release would look like a
  // fall; only trust edges once the chain holds real pin samples.
  assign armed     = (warm == 2'd3);
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign cs_rise   = cs_p1 & ~cs_p2;
  assign cs_fall   = armed & cs_p2 & ~cs_p1;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall && ena) state_nxt = SHIFT;
      SHIFT: begin
        if (!ena)
          state_nxt = IDLE;
        else if (cs_rise)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage shift: an sclk edge coinciding with the cs_n rise is dropped
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          shreg <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          if (ena && !cs_rise && sclk_rise) begin
            shreg <= {shreg[FRAME_W-2:0], mosi_p2};
            cnt   <= cnt_sat_inc(cnt);
          end
        end
        default: ;
      endcase
    end
  end

  // Stage output: frame verdict taken in DONE
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      hdr_o       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      if (state == DONE) begin
        if (cnt == CNT_FULL) begin
          hdr_o   <= shreg[FRAME_W-1 -: HDR_W];
          data_o  <= shreg[DATA_W-1:0];
          valid_o <= 1'b1;
        end else begin
          frame_err_o <= 1'b1;
        end
      end
    end
  end

  assign busy_o = (state == SHIFT);

endmodule
